// File: rtl/chunked_serial_adder.sv
// ---------------------------------------------------------------------------
// chunked_serial_adder
//
// Multi-cycle adder for the systolic array datapath. Two WIDTH-bit operands
// plus a carry-in are summed CHUNK bits per clock. A single carry register
// links consecutive chunks, so the longest combinational carry chain is
// CHUNK bits rather than WIDTH bits.
//
// Build option:
//   SUBTRACT_EN  - when defined, adds the `sub` port. sub=1 computes
//                  a - b - cin as a + ~b + ~cin (cout=1 means no borrow).
//                  When undefined the block only adds.
//
// Parameters:
//   WIDTH  operand / result width (default 16)
//   CHUNK  bits added per cycle (default 4); WIDTH must be a multiple
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands valid
//   in_ready   out  block can accept operands (0 while in reset)
//   a, b       in   WIDTH-bit operands
//   cin        in   carry-in (borrow-in when subtracting)
//   sub        in   1 = subtract (SUBTRACT_EN builds only)
//   out_valid  out  result valid
//   out_ready  in   consumer accepts result
//   sum        out  WIDTH-bit result
//   cout       out  carry out of the MSB
//   overflow   out  signed overflow
// ---------------------------------------------------------------------------
module chunked_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SUBTRACT_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("chunked_serial_adder: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;        // already inverted for subtract
    logic              carry_q;
    logic [KW-1:0]     k_q;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              ovf_q;

    logic              sub_eff;
    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;
    logic              accept;
    logic              last_chunk;

    logic [IW-1:0]     base;
    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;
    logic [CHUNK:0]    chunk_res;
    logic              msb_cin;

`ifdef SUBTRACT_EN
    assign sub_eff = sub;
`else
    assign sub_eff = 1'b0;
`endif

    // Subtraction folds into the adder: invert b and the incoming carry once
    // at accept so the RUN datapath is identical for both modes.
    assign b_eff   = sub_eff ? ~b : b;
    assign cin_eff = cin ^ sub_eff;

    assign accept     = in_valid & in_ready;
    assign last_chunk = (k_q == KW'(NCHUNK - 1));

    // ---------------------------------------------------------------------
    // Chunk datapath
    // ---------------------------------------------------------------------
    always_comb begin
        base      = IW'(k_q) * IW'(CHUNK);
        a_chunk   = a_q[base +: CHUNK];
        b_chunk   = b_q[base +: CHUNK];
        chunk_res = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        // Carry into the top bit of this chunk, recovered from the sum bit;
        // only meaningful on the final chunk where it is the MSB carry-in.
        msb_cin   = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_res[CHUNK-1];
    end

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Next state and handshake outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_chunk) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = rst_n & out_ready;
                if (out_ready) begin
                    state_nxt = in_valid ? RUN : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Operand, carry and result registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b_eff;
            carry_q <= cin_eff;
            k_q     <= '0;
        end else if (state == RUN) begin
            sum_q[base +: CHUNK] <= chunk_res[CHUNK-1:0];
            carry_q              <= chunk_res[CHUNK];
            if (last_chunk) begin
                k_q    <= '0;
                cout_q <= chunk_res[CHUNK];
                ovf_q  <= msb_cin ^ chunk_res[CHUNK];
            end else begin
                k_q    <= k_q + KW'(1);
            end
        end
    end

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule
